// File: rtl/mmu_pkg.sv
// Shared types and helpers for the matrix multiply unit accumulator stage.
package mmu_pkg;

   localparam int LANES = 16;
   localparam int IN_W  = 20;
   localparam int ACC_W = 24;
   localparam int OUT_W = 8;

   typedef logic signed [IN_W-1:0]  lane_sum_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [OUT_W-1:0] q8_t;

   typedef enum logic {ACC, HOLD} st_e;

   // Clamp a signed value to the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                       input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/mmu_requant_lane.sv
// One lane of requantization: floor shift by Q, optional ReLU, clamp to int8.
module mmu_requant_lane
   import mmu_pkg::*;
#(
   parameter int ACC_W = mmu_pkg::ACC_W,
   parameter int Q     = 4
)(
   input  logic signed [ACC_W-1:0] sum_i,
   input  logic                    relu_en_i,
   output logic signed [OUT_W-1:0] q_o,
   output logic                    clamp_o
);

   localparam int QMAX = (1 << (OUT_W - 1)) - 1;
   localparam int QMIN = -(1 << (OUT_W - 1));

   logic signed [ACC_W-1:0] r;
   logic signed [31:0]      rv;

   always_comb begin
      r       = sum_i >>> Q;
      rv      = 32'(r);
      clamp_o = 1'b0;
      if (relu_en_i && rv < 0) rv = '0;
      if (rv > QMAX) begin
         rv      = QMAX;
         clamp_o = 1'b1;
      end else if (rv < QMIN) begin
         rv      = QMIN;
         clamp_o = 1'b1;
      end
      q_o = rv[OUT_W-1:0];
   end

endmodule

// File: rtl/mmu_accumulator.sv
// Per-column saturating accumulation across K-tiles with int8 requantized
// output presented through a one-entry valid/ready result register.
module mmu_accumulator
   import mmu_pkg::*;
#(
   parameter int LANES = mmu_pkg::LANES,
   parameter int IN_W  = mmu_pkg::IN_W,
   parameter int ACC_W = mmu_pkg::ACC_W,
   parameter int Q     = 4
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic                   in_last,
   input  logic                   relu_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [15:0]            beat_cnt,
   output logic                   sat_flag
);

   st_e                          state_q, state_d;
   logic [LANES*OUT_W-1:0]       out_data_q;
   logic [15:0]                  beat_cnt_q;
   logic                         sat_q, sat_d;
   logic [LANES-1:0]             acc_sat, q_sat;
   logic [LANES-1:0][OUT_W-1:0]  q8;
   logic                         accept, acc_last, xfer, sat_set;

   assign out_valid = (state_q == HOLD);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign acc_last  = accept && in_last;
   assign xfer      = out_valid && out_ready;
   assign out_data  = out_data_q;
   assign beat_cnt  = beat_cnt_q;
   assign sat_flag  = sat_q;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic signed [ACC_W-1:0] acc_q;
      logic signed [ACC_W-1:0] lane_s;
      logic signed [IN_W-1:0]  in_lane;
      logic signed [63:0]      sum_w, sat_w;

      assign in_lane = in_data[IN_W*j +: IN_W];

      always_comb begin
         sum_w      = 64'(acc_q) + 64'(in_lane);
         sat_w      = sat_to_width(sum_w, ACC_W);
         lane_s     = sat_w[ACC_W-1:0];
         acc_sat[j] = (sat_w != sum_w);
      end

      // The last beat's sum goes straight to requant; the accumulator restarts at zero.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)    acc_q <= '0;
         else if (accept) acc_q <= in_last ? '0 : lane_s;
      end

      mmu_requant_lane #(.ACC_W(ACC_W), .Q(Q)) u_rq (
         .sum_i     (lane_s),
         .relu_en_i (relu_en),
         .q_o       (q8[j]),
         .clamp_o   (q_sat[j])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC:     if (acc_last) state_d = HOLD;
         HOLD:    if (out_ready && !acc_last) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // A new flag event on the transfer edge must survive the clear.
   assign sat_set = accept && ((|acc_sat) || (in_last && (|q_sat)));
   assign sat_d   = sat_set ? 1'b1 : (xfer ? 1'b0 : sat_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ACC;
         out_data_q <= '0;
         beat_cnt_q <= '0;
         sat_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         sat_q   <= sat_d;
         if (acc_last) begin
            out_data_q <= q8;
            beat_cnt_q <= '0;
         end else if (accept && beat_cnt_q != 16'hFFFF) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mmu_accumulator.sv
// Directed checks of accumulate, requantize, saturation, backpressure and reset.
module tb_mmu_accumulator;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid, in_ready, in_last, relu_en;
   logic [319:0] in_data;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic [15:0]  beat_cnt;
   logic         sat_flag;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mmu_accumulator dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .beat_cnt  (beat_cnt),
      .sat_flag  (sat_flag)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [319:0] all_lanes(input logic [19:0] v);
      logic [319:0] d;
      for (int i = 0; i < 16; i++) d[20*i +: 20] = v;
      return d;
   endfunction

   function automatic logic [319:0] one_lane(input int j, input logic [19:0] v);
      logic [319:0] d;
      d = '0;
      d[20*j +: 20] = v;
      return d;
   endfunction

   function automatic logic [127:0] all_bytes(input logic [7:0] b);
      logic [127:0] d;
      for (int i = 0; i < 16; i++) d[8*i +: 8] = b;
      return d;
   endfunction

   task automatic beat(input logic [319:0] d, input logic last, input logic relu);
      in_data  = d;
      in_last  = last;
      relu_en  = relu;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      relu_en   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #8;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data",  out_data, 128'd0);
      chk("rst_beat_cnt",  128'(beat_cnt), 128'd0);
      chk("rst_sat_flag",  128'(sat_flag), 128'd0);
      chk("rst_in_ready",  128'(in_ready), 128'd1);
      #4 reset_n = 1'b1;

      // 160 >>> 4 = 10 in every lane
      beat(all_lanes(20'd160), 1'b1, 1'b0);
      chk("t1_out_valid", 128'(out_valid), 128'd1);
      chk("t1_out_data",  out_data, all_bytes(8'h0A));
      chk("t1_sat_flag",  128'(sat_flag), 128'd0);
      chk("t1_beat_cnt",  128'(beat_cnt), 128'd0);
      @(posedge clk); #1;
      chk("t1_drain", 128'(out_valid), 128'd0);

      // -300 >>> 4 = -19; ReLU forces 0
      beat(one_lane(0, 20'hFFF9C), 1'b0, 1'b0);
      beat(one_lane(0, 20'hFFF9C), 1'b0, 1'b0);
      chk("t2_beat_cnt", 128'(beat_cnt), 128'd2);
      beat(one_lane(0, 20'hFFF9C), 1'b1, 1'b1);
      chk("t2_relu_valid", 128'(out_valid), 128'd1);
      chk("t2_relu_data",  out_data, 128'd0);
      beat(one_lane(0, 20'hFFF9C), 1'b0, 1'b0);
      beat(one_lane(0, 20'hFFF9C), 1'b0, 1'b0);
      beat(one_lane(0, 20'hFFF9C), 1'b1, 1'b0);
      chk("t2_neg_data", out_data, 128'h0000_0000_0000_0000_0000_0000_0000_00ED);
      @(posedge clk); #1;

      // 17th beat of +524287 exceeds the 24-bit range
      for (int i = 0; i < 19; i++) beat(one_lane(3, 20'h7FFFF), 1'b0, 1'b0);
      chk("t3_beat_cnt", 128'(beat_cnt), 128'd19);
      chk("t3_acc_sat",  128'(sat_flag), 128'd1);
      out_ready = 1'b0;
      beat(one_lane(3, 20'h7FFFF), 1'b1, 1'b0);
      chk("t3_out_valid", 128'(out_valid), 128'd1);
      chk("t3_out_data",  out_data, 128'h0000_0000_0000_0000_0000_0000_7F00_0000);
      chk("t3_sat_hold",  128'(sat_flag), 128'd1);

      // Backpressure: an offered beat must not be taken
      in_data  = all_lanes(20'd5);
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready",  128'(in_ready), 128'd0);
         chk("bp_out_data",  out_data, 128'h0000_0000_0000_0000_0000_0000_7F00_0000);
         chk("bp_beat_cnt",  128'(beat_cnt), 128'd0);
         chk("bp_sat_flag",  128'(sat_flag), 128'd1);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_ready_comb", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      chk("bp_xfer_valid", 128'(out_valid), 128'd0);
      chk("bp_sat_clear",  128'(sat_flag), 128'd0);
      chk("bp_in_ready2",  128'(in_ready), 128'd1);

      // Back-to-back single-beat tiles: 16 -> 1, 48 -> 3
      beat(all_lanes(20'd16), 1'b1, 1'b0);
      chk("b2b_valid0", 128'(out_valid), 128'd1);
      chk("b2b_data0",  out_data, all_bytes(8'h01));
      beat(all_lanes(20'd48), 1'b1, 1'b0);
      chk("b2b_valid1", 128'(out_valid), 128'd1);
      chk("b2b_data1",  out_data, all_bytes(8'h03));
      @(posedge clk); #1;
      chk("b2b_drain", 128'(out_valid), 128'd0);

      // Asynchronous reset mid-tile drops the partial sums
      beat(all_lanes(20'd100), 1'b0, 1'b0);
      beat(all_lanes(20'd100), 1'b0, 1'b0);
      chk("rm_beat_cnt", 128'(beat_cnt), 128'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("rm_out_valid", 128'(out_valid), 128'd0);
      chk("rm_beat_cnt0", 128'(beat_cnt), 128'd0);
      #2 reset_n = 1'b1;
      beat(all_lanes(20'd32), 1'b1, 1'b0);
      chk("rm_valid", 128'(out_valid), 128'd1);
      chk("rm_data",  out_data, all_bytes(8'h02));
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
